knapsack_seq_checker: RTL and testbench

Parametrised sequential successor to the team's combinational knapsack verifier. Holds a programmable table of N_ITEMS (value, weight) pairs and checks a proposed selection against run-time thresholds. Accumulates one item per cycle under an FSM and reports a registered valid/done result. Sits behind the selection generator as the decision-problem oracle: value >= min_value and weight <= max_weight.

---
 rtl/knapsack_seq_checker.sv | 161 ++++++++++++++++
 tb/tb_knapsack_seq_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/knapsack_seq_checker.sv
// rtl/knapsack_seq_checker.sv - sequential knapsack selection checker, one item per cycle
// Define KNAPSACK_EARLY_ABORT_EN to end a run as soon as the weight threshold is exceeded.
module knapsack_seq_checker #(
    parameter int N_ITEMS = 5,
    parameter int VAL_W   = 8,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 32,
    parameter int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [VAL_W-1:0]   cfg_value,
    input  logic [WGT_W-1:0]   cfg_weight,
    input  logic               start,
    input  logic [N_ITEMS-1:0] sel,
    input  logic [ACC_W-1:0]   min_value,
    input  logic [ACC_W-1:0]   max_weight,
    output logic               ready,
    output logic               done,
    output logic               valid,
    output logic               aborted,
    output logic [ACC_W-1:0]   total_value,
    output logic [ACC_W-1:0]   total_weight
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   tbl_val_q [N_ITEMS];
    logic [VAL_W-1:0]   tbl_val_d [N_ITEMS];
    logic [WGT_W-1:0]   tbl_wgt_q [N_ITEMS];
    logic [WGT_W-1:0]   tbl_wgt_d [N_ITEMS];
    logic [N_ITEMS-1:0] sel_q, sel_d;
    logic [ACC_W-1:0]   min_q, min_d, max_q, max_d;
    logic [ACC_W-1:0]   tv_q, tv_d, tw_q, tw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ready_q, ready_d, done_q, done_d;
    logic               valid_q, valid_d, aborted_q, aborted_d;

    logic [ACC_W:0]     v_sum, w_sum;
    logic [ACC_W-1:0]   v_acc, w_acc;
    logic               last_item, abort_hit;

    // Saturating add of the current item; the carry-out bit flags overflow.
    always_comb begin
        v_sum = {1'b0, tv_q} + (ACC_W+1)'(tbl_val_q[idx_q]);
        w_sum = {1'b0, tw_q} + (ACC_W+1)'(tbl_wgt_q[idx_q]);
        v_acc = v_sum[ACC_W] ? '1 : v_sum[ACC_W-1:0];
        w_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        if (!sel_q[idx_q]) begin
            v_acc = tv_q;
            w_acc = tw_q;
        end
    end

    assign last_item = (idx_q == IDX_W'(N_ITEMS - 1));
`ifdef KNAPSACK_EARLY_ABORT_EN
    assign abort_hit = (w_acc > max_q);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        tbl_val_d = tbl_val_q;
        tbl_wgt_d = tbl_wgt_q;
        if (cfg_we && (32'(cfg_addr) < N_ITEMS)) begin
            tbl_val_d[cfg_addr] = cfg_value;
            tbl_wgt_d[cfg_addr] = cfg_weight;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        min_d     = min_q;
        max_d     = max_q;
        tv_d      = tv_q;
        tw_d      = tw_q;
        idx_d     = idx_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = sel;
                    min_d     = min_value;
                    max_d     = max_weight;
                    tv_d      = '0;
                    tw_d      = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    aborted_d = 1'b0;
                    ready_d   = 1'b0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                tv_d  = v_acc;
                tw_d  = w_acc;
                idx_d = idx_q + IDX_W'(1);
                if (abort_hit || last_item) begin
                    idx_d     = '0;
                    done_d    = 1'b1;
                    aborted_d = abort_hit;
                    valid_d   = !abort_hit && (v_acc >= min_q) && (w_acc <= max_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tbl_val_q <= '{default: '0};
            tbl_wgt_q <= '{default: '0};
            sel_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            tv_q      <= '0;
            tw_q      <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_val_q <= tbl_val_d;
            tbl_wgt_q <= tbl_wgt_d;
            sel_q     <= sel_d;
            min_q     <= min_d;
            max_q     <= max_d;
            tv_q      <= tv_d;
            tw_q      <= tw_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            aborted_q <= aborted_d;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign valid        = valid_q;
    assign aborted      = aborted_q;
    assign total_value  = tv_q;
    assign total_weight = tw_q;
endmodule

// File: tb/tb_knapsack_seq_checker.sv
// tb/tb_knapsack_seq_checker.sv - bench for knapsack_seq_checker at ACC_W=32 and ACC_W=8
module tb_knapsack_seq_checker;
    localparam int N = 5;
`ifdef KNAPSACK_EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_value = '0, cfg_weight = '0;
    logic        start = 1'b0;
    logic [4:0]  sel = '0;
    logic [31:0] min_value = '0, max_weight = '0;
    logic [7:0]  min8 = '0, max8 = '0;

    logic        r0, d0, v0, a0, r1, d1, v1, a1;
    logic [31:0] tv0, tw0;
    logic [7:0]  tv1, tw1;

    knapsack_seq_checker dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_value(cfg_value), .cfg_weight(cfg_weight), .start(start), .sel(sel),
        .min_value(min_value), .max_weight(max_weight), .ready(r0), .done(d0),
        .valid(v0), .aborted(a0), .total_value(tv0), .total_weight(tw0)
    );

    knapsack_seq_checker #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_value(cfg_value), .cfg_weight(cfg_weight), .start(start), .sel(sel),
        .min_value(min8), .max_weight(max8), .ready(r1), .done(d1),
        .valid(v1), .aborted(a1), .total_value(tv1), .total_weight(tw1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: shared item table, one run tracker per accumulator width.
    longint t_val [N];
    longint t_wgt [N];
    longint m_tv [2], m_tw [2], m_min [2], m_max [2];
    logic [4:0] m_sel [2];
    int     m_pos [2];
    bit     m_busy [2], m_fin [2];
    bit     e_ready [2], e_done [2], e_valid [2], e_abort [2];
    bit     m_init = 1'b0;

    function automatic longint sat(longint x, int m);
        longint lim;
        lim = (m == 0) ? 64'hFFFF_FFFF : 64'd255;
        return (x > lim) ? lim : x;
    endfunction

    initial begin : model
        bit ab;
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                if (rst) begin
                    m_busy[m] = 0; m_fin[m] = 0; e_ready[m] = 1; e_done[m] = 0;
                    e_valid[m] = 0; e_abort[m] = 0; m_tv[m] = 0; m_tw[m] = 0;
                end else begin
                    e_done[m] = 0;
                    if (m_fin[m]) begin
                        m_fin[m] = 0;
                        e_ready[m] = 1;
                    end else if (m_busy[m]) begin
                        if (m_sel[m][m_pos[m]]) begin
                            m_tv[m] = sat(m_tv[m] + t_val[m_pos[m]], m);
                            m_tw[m] = sat(m_tw[m] + t_wgt[m_pos[m]], m);
                        end
                        m_pos[m]++;
                        ab = ABORT_EN && (m_tw[m] > m_max[m]);
                        if (ab || m_pos[m] == N) begin
                            e_abort[m] = ab;
                            e_valid[m] = !ab && (m_tv[m] >= m_min[m]) && (m_tw[m] <= m_max[m]);
                            e_done[m] = 1; m_busy[m] = 0; m_fin[m] = 1;
                        end
                    end else if (start && e_ready[m]) begin
                        m_sel[m] = sel;
                        m_min[m] = (m == 0) ? longint'(min_value) : longint'(min8);
                        m_max[m] = (m == 0) ? longint'(max_weight) : longint'(max8);
                        m_tv[m] = 0; m_tw[m] = 0; e_valid[m] = 0; e_abort[m] = 0;
                        m_busy[m] = 1; m_pos[m] = 0; e_ready[m] = 0;
                    end
                end
            end
            if (rst) begin
                for (int i = 0; i < N; i++) begin t_val[i] = 0; t_wgt[i] = 0; end
                m_init = 1'b1;
            end else if (cfg_we && cfg_addr < N) begin
                t_val[cfg_addr] = cfg_value;
                t_wgt[cfg_addr] = cfg_weight;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_init) begin
                checks++;
                if (r0 !== e_ready[0] || d0 !== e_done[0] || v0 !== e_valid[0] ||
                    a0 !== e_abort[0] || tv0 !== 32'(m_tv[0]) || tw0 !== 32'(m_tw[0])) begin
                    errors++;
                    $display("FAIL cyc32 t=%0t act r=%0b d=%0b v=%0b a=%0b tv=%0d tw=%0d req r=%0b d=%0b v=%0b a=%0b tv=%0d tw=%0d",
                             $time, r0, d0, v0, a0, tv0, tw0, e_ready[0], e_done[0], e_valid[0], e_abort[0], m_tv[0], m_tw[0]);
                end
                checks++;
                if (r1 !== e_ready[1] || d1 !== e_done[1] || v1 !== e_valid[1] ||
                    a1 !== e_abort[1] || tv1 !== 8'(m_tv[1]) || tw1 !== 8'(m_tw[1])) begin
                    errors++;
                    $display("FAIL cyc8 t=%0t act r=%0b d=%0b v=%0b a=%0b tv=%0d tw=%0d req r=%0b d=%0b v=%0b a=%0b tv=%0d tw=%0d",
                             $time, r1, d1, v1, a1, tv1, tw1, e_ready[1], e_done[1], e_valid[1], e_abort[1], m_tv[1], m_tw[1]);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s act=%0d req=%0d", nm, act, req);
        end
    endtask

    task automatic wr(input int a, input int v, input int w);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_value = 8'(v); cfg_weight = 8'(w);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    int c_lat;
    longint c_tv, c_tw;
    bit c_v, c_a;

    task automatic run(input logic [4:0] s, input logic [31:0] mn, input logic [31:0] mx,
                       input logic [7:0] mn8, input logic [7:0] mx8);
        start = 1'b1; sel = s; min_value = mn; max_weight = mx; min8 = mn8; max8 = mx8;
        @(negedge clk);
        start = 1'b0;
        c_lat = 1;
        while (d0 !== 1'b1 && c_lat < 20) begin
            @(negedge clk);
            c_lat++;
        end
        c_tv = tv0; c_tw = tw0; c_v = v0; c_a = a0;
        repeat (8) @(negedge clk);
    endtask

    initial begin : stim
        bit saw;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", r0, 1); chk("rst_done", d0, 0); chk("rst_valid", v0, 0);
        chk("rst_abort", a0, 0); chk("rst_tv", tv0, 0); chk("rst_tw", tw0, 0);

        wr(0, 4, 12); wr(1, 2, 1); wr(2, 2, 2); wr(3, 1, 1); wr(4, 10, 4);
        wr(6, 99, 99);

        run(5'b11110, 15, 16, 15, 16);
        chk("t1_lat", c_lat, 6); chk("t1_tv", c_tv, 15); chk("t1_tw", c_tw, 8);
        chk("t1_valid", c_v, 1); chk("t1_abort", c_a, 0);

        run(5'b11111, 15, 16, 15, 16);
        chk("t2_lat", c_lat, 6); chk("t2_tv", c_tv, 19); chk("t2_tw", c_tw, 20);
        chk("t2_valid", c_v, 0); chk("t2_abort", c_a, ABORT_EN ? 1 : 0);

        wr(0, 4, 20);
        run(5'b11111, 15, 16, 15, 16);
        chk("t3_lat", c_lat, ABORT_EN ? 2 : 6);
        chk("t3_tw", c_tw, ABORT_EN ? 20 : 28);
        chk("t3_tv", c_tv, ABORT_EN ? 4 : 19);
        chk("t3_valid", c_v, 0); chk("t3_abort", c_a, ABORT_EN ? 1 : 0);

        run(5'b00000, 0, 16, 0, 16);
        chk("sel0_valid", c_v, 1); chk("sel0_tv", c_tv, 0); chk("sel0_tw", c_tw, 0);
        run(5'b00000, 1, 16, 1, 16);
        chk("sel0_min1_valid", c_v, 0);

        for (int i = 0; i < N; i++) wr(i, 10, 200);
        run(5'b11111, 50, 255, 50, 255);
        chk("sat8_tw", tw1, 255); chk("sat8_tv", tv1, 50); chk("sat8_valid", v1, 1);
        chk("sat32_tw", c_tw, ABORT_EN ? 400 : 1000);
        run(5'b11111, 50, 255, 51, 255);
        chk("sat8_min51_valid", v1, 0);

        saw = 0;
        start = 1'b1; sel = 5'b11111; min_value = 0; max_weight = 32'hFFFF_FFFF; min8 = 0; max8 = 8'hFF;
        @(negedge clk); start = 1'b0; saw |= d0;
        @(negedge clk); saw |= d0;
        @(negedge clk); saw |= d0;
        rst = 1'b1;
        @(negedge clk); saw |= d0;
        rst = 1'b0;
        repeat (4) begin @(negedge clk); saw |= d0; end
        chk("midrst_no_done", saw, 0);
        chk("midrst_ready", r0, 1); chk("midrst_tv", tv0, 0); chk("midrst_tw", tw0, 0);
        run(5'b11111, 0, 100, 0, 100);
        chk("postrst_lat", c_lat, 6); chk("postrst_tv", c_tv, 0);
        chk("postrst_tw", c_tw, 0); chk("postrst_valid", c_v, 1);

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            sel = 5'($urandom);
            min_value = $urandom_range(0, 700);
            max_weight = $urandom_range(0, 700);
            min8 = 8'($urandom);
            max8 = 8'($urandom);
            cfg_we = ($urandom_range(0, 2) == 0);
            cfg_addr = 3'($urandom);
            cfg_value = 8'($urandom);
            cfg_weight = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        start = 1'b0; cfg_we = 1'b0; rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end
endmodule
